// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch for the MIPS datapath with a valid/ready handshake,
// a 2-entry skid buffer, a synchronous flush and a saturating stall counter.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter int M_W        = 4,
  parameter int JIDX_W     = 28,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        add2,
  input  logic [DATA_W-1:0]        resulalu,
  input  logic [DATA_W-1:0]        rd2,
  input  logic [REG_ADDR_W-1:0]    mux,
  input  logic                     zero,
  input  logic [WB_W-1:0]          wb,
  input  logic [M_W-1:0]           m,
  input  logic [JIDX_W-1:0]        instTipoJ,
  input  logic [DATA_W-JIDX_W-1:0] add131_28,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        salidAdd2,
  output logic [DATA_W-1:0]        salidaresulalu,
  output logic [DATA_W-1:0]        salidard2,
  output logic [REG_ADDR_W-1:0]    salidamux,
  output logic                     salidaZero,
  output logic [WB_W-1:0]          salida_wb,
  output logic [M_W-1:0]           salida_m,
  output logic [DATA_W-1:0]        salidainstTipoJ,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]     add2;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd2;
    logic [REG_ADDR_W-1:0] mux;
    logic                  zero;
    logic [WB_W-1:0]       wb;
    logic [M_W-1:0]        m;
    logic [DATA_W-1:0]     jt;
  } pkt_t;

  // state is kept as a named register so checkers can bind to it directly.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  pkt_t   main_q;
  pkt_t   skid_q;
  pkt_t   in_pkt;
  logic   accept;
  logic   fire;

  // Handshake: a beat moves on a side when both valid and ready are high there;
  // in_ready depends only on state (and reset), never on out_ready.
  assign in_ready  = (state != TWO) & ~rst;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    in_pkt      = '0;
    in_pkt.add2 = add2;
    in_pkt.alu  = resulalu;
    in_pkt.rd2  = rd2;
    in_pkt.mux  = mux;
    in_pkt.zero = zero;
    in_pkt.wb   = wb;
    in_pkt.m    = m;
    in_pkt.jt   = {add131_28, instTipoJ};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_pkt;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_q <= in_pkt;
          end else if (accept) begin
            state  <= TWO;
            skid_q <= in_pkt;
          end else if (fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign salidAdd2       = main_q.add2;
  assign salidaresulalu  = main_q.alu;
  assign salidard2       = main_q.rd2;
  assign salidamux       = main_q.mux;
  assign salidaZero      = main_q.zero;
  assign salidainstTipoJ = main_q.jt;
  // Bubbles must never carry live write-back or memory control.
  assign salida_wb       = out_valid ? main_q.wb : '0;
  assign salida_m        = out_valid ? main_q.m  : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: handshake, skid ordering, flush, reset and
// stall-counter saturation (second instance with a 2-bit counter).
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] add2;
  logic [31:0] resulalu;
  logic [31:0] rd2;
  logic [4:0]  mux;
  logic        zero;
  logic [1:0]  wb;
  logic [3:0]  m;
  logic [27:0] instTipoJ;
  logic [3:0]  add131_28;
  logic        out_ready;

  logic        in_ready, out_valid, salidaZero;
  logic [31:0] salidAdd2, salidaresulalu, salidard2, salidainstTipoJ;
  logic [4:0]  salidamux;
  logic [1:0]  salida_wb;
  logic [3:0]  salida_m;
  logic [15:0] stall_cnt;

  logic        c2_in_ready, c2_out_valid, c2_zero;
  logic [31:0] c2_add2, c2_alu, c2_rd2, c2_jt;
  logic [4:0]  c2_mux;
  logic [1:0]  c2_wb;
  logic [3:0]  c2_m;
  logic [1:0]  c2_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .add2(add2), .resulalu(resulalu), .rd2(rd2), .mux(mux), .zero(zero), .wb(wb),
    .m(m), .instTipoJ(instTipoJ), .add131_28(add131_28), .out_valid(out_valid),
    .out_ready(out_ready), .salidAdd2(salidAdd2), .salidaresulalu(salidaresulalu),
    .salidard2(salidard2), .salidamux(salidamux), .salidaZero(salidaZero),
    .salida_wb(salida_wb), .salida_m(salida_m), .salidainstTipoJ(salidainstTipoJ),
    .stall_cnt(stall_cnt)
  );

  ex_mem_stage #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c2_in_ready),
    .add2(add2), .resulalu(resulalu), .rd2(rd2), .mux(mux), .zero(zero), .wb(wb),
    .m(m), .instTipoJ(instTipoJ), .add131_28(add131_28), .out_valid(c2_out_valid),
    .out_ready(out_ready), .salidAdd2(c2_add2), .salidaresulalu(c2_alu),
    .salidard2(c2_rd2), .salidamux(c2_mux), .salidaZero(c2_zero),
    .salida_wb(c2_wb), .salida_m(c2_m), .salidainstTipoJ(c2_jt),
    .stall_cnt(c2_stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: secondary fields are derived from the ALU value so every packet is distinct
  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] d,
                       input logic [1:0] w, input logic [3:0] mm,
                       input logic [3:0] hi, input logic [27:0] jidx);
    in_valid  = v;
    resulalu  = alu;
    add2      = alu ^ 32'hFFFF_0000;
    rd2       = alu + 32'd1;
    zero      = alu[0];
    mux       = d;
    wb        = w;
    m         = mm;
    add131_28 = hi;
    instTipoJ = jidx;
  endtask

  // scoreboard: every beat leaving the stage must be the next expected packet
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got alu 0x%08h expected no beat at %0t", salidaresulalu, $time);
      end else begin
        check("order", salidaresulalu, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_alu", salidaresulalu, 32'd0);
    check("rst_jt", salidainstTipoJ, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic beat plus jump-target assembly
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00A5, 5'd9, 2'b10, 4'h3, 4'h4, 28'h000_0100);
    exp_q.push_back(32'h0000_00A5);
    tick();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_alu", salidaresulalu, 32'h0000_00A5);
    check("t1_mux", 32'(salidamux), 32'd9);
    check("t1_wb", 32'(salida_wb), 32'd2);
    check("t1_m", 32'(salida_m), 32'd3);
    check("t1_add2", salidAdd2, 32'hFFFF_00A5);
    check("t1_rd2", salidard2, 32'h0000_00A6);
    check("t1_zero", 32'(salidaZero), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t2_jt", salidainstTipoJ, 32'h4000_0100);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    tick();
    check("t1_drain_valid", 32'(out_valid), 32'd0);
    check("t1_drain_wb", 32'(salida_wb), 32'd0);

    // back-pressure with skid buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 2'b01, 4'h1, 4'hA, 28'h000_0011);
    exp_q.push_back(32'h11);
    tick();
    check("t3_a_alu", salidaresulalu, 32'h11);
    check("t3_a_stall", 32'(stall_cnt), 32'd0);
    check("t3_a_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h22, 5'd2, 2'b10, 4'h2, 4'hB, 28'h000_0022);
    exp_q.push_back(32'h22);
    tick();
    check("t3_b_in_ready", 32'(in_ready), 32'd0);
    check("t3_b_alu", salidaresulalu, 32'h11);
    check("t3_b_stall", 32'(stall_cnt), 32'd1);
    drive(1'b1, 32'h33, 5'd3, 2'b11, 4'h3, 4'hC, 28'h000_0033);
    exp_q.push_back(32'h33);
    tick();
    check("t3_c_in_ready", 32'(in_ready), 32'd0);
    check("t3_c_stall", 32'(stall_cnt), 32'd2);
    check("t3_c_alu", salidaresulalu, 32'h11);
    tick();
    check("t3_d_stall", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    check("t3_e_alu", salidaresulalu, 32'h22);
    check("t3_e_in_ready", 32'(in_ready), 32'd1);
    check("t3_e_stall", 32'(stall_cnt), 32'd3);
    check("t3_e_jt", salidainstTipoJ, 32'hB000_0022);
    tick();
    check("t3_f_alu", salidaresulalu, 32'h33);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    tick();
    check("t3_g_out_valid", 32'(out_valid), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // flush while full, with a beat offered in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h44, 5'd4, 2'b11, 4'hF, 4'h1, 28'h000_0044);
    tick();
    drive(1'b1, 32'h55, 5'd5, 2'b11, 4'hE, 4'h1, 28'h000_0055);
    tick();
    check("t4_full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h66, 5'd6, 2'b11, 4'hD, 4'h1, 28'h000_0066);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_m", 32'(salida_m), 32'd0);
    check("t4_wb", 32'(salida_wb), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_stall", 32'(stall_cnt), 32'd5);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    out_ready = 1'b1;
    tick(); tick();
    check("t4_still_empty", 32'(out_valid), 32'd0);

    // asynchronous reset mid-cycle while holding one packet
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 5'd7, 2'b11, 4'hF, 4'h7, 28'h000_0077);
    tick();
    check("t5_held", salidaresulalu, 32'h77);
    #3;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_alu", salidaresulalu, 32'd0);
    check("t5_m", 32'(salida_m), 32'd0);
    check("t5_jt", salidainstTipoJ, 32'd0);
    check("t5_stall", 32'(stall_cnt), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h88, 5'd8, 2'b11, 4'hF, 4'h8, 28'h000_0088);
    tick();
    check("t5_ignored", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    rst = 1'b0;
    tick();
    check("t5_release_empty", 32'(out_valid), 32'd0);

    // first beat after reset, then stall-counter saturation on the 2-bit instance
    drive(1'b1, 32'h99, 5'd10, 2'b01, 4'h5, 4'h9, 28'h000_0099);
    exp_q.push_back(32'h99);
    tick();
    check("t5_first_alu", salidaresulalu, 32'h99);
    check("t5_first_valid", 32'(out_valid), 32'd1);
    check("t6_start", 32'(c2_stall_cnt), 32'd0);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 4'h0, 28'h0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("t6_c2_stall_%0d", i), 32'(c2_stall_cnt), (i < 3) ? 32'(i) : 32'd3);
      check($sformatf("t6_stall_%0d", i), 32'(stall_cnt), 32'(i));
    end
    out_ready = 1'b1;
    tick();
    check("t6_drain", 32'(out_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline stage for the MIPS datapath.
- Registers the EX results, write-back and memory control fields, and the assembled jump target, as the fixed EX/MEM latch does.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, a synchronous flush that turns the stage into a bubble, and a saturating back-pressure cycle counter.
- Sits between the ALU/branch-adder stage and the data-memory stage.

Parameters:
DATA_W, 32, width of branch target, ALU result, rd2 and jump target
REG_ADDR_W, 5, destination register index width
WB_W, 2, write-back control field width
M_W, 4, memory control field width
JIDX_W, 28, jump index width (instr[25:0]<<2); PC high-part width is DATA_W-JIDX_W
CNT_W, 16, width of stall counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  EX stage presents a beat
in_ready  out  1  stage can accept a beat
add2  in  DATA_W  branch target
resulalu  in  DATA_W  ALU result
rd2  in  DATA_W  store data
mux  in  REG_ADDR_W  destination register
zero  in  1  ALU zero flag
wb  in  WB_W  write-back control
m  in  M_W  memory control
instTipoJ  in  JIDX_W  shifted jump index
add131_28  in  DATA_W-JIDX_W  PC+4 high bits
out_valid  out  1  output beat valid
out_ready  in  1  MEM stage accepts beat
salidAdd2, salidaresulalu, salidard2  out  DATA_W  registered copies
salidamux  out  REG_ADDR_W  registered destination
salidaZero  out  1  registered zero flag
salida_wb  out  WB_W  registered wb; forced 0 when out_valid=0
salida_m  out  M_W  registered m; forced 0 when out_valid=0
salidainstTipoJ  out  DATA_W  jump target {add131_28, instTipoJ}
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: a main register that drives the outputs and a skid register. Each holds a full packet: all data fields, wb, m, and the concatenated jump target formed at capture.
- Handshake signals: accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = (state != TWO) & ~rst. in_ready is a function of state only; there is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- State machine:
  - EMPTY: accept -> ONE, main <= in.
  - ONE, accept & fire -> ONE, main <= in.
  - ONE, accept & ~fire -> TWO, skid <= in.
  - ONE, ~accept & fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: fire -> ONE, main <= skid; otherwise hold. No accept is possible in TWO.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Packets leave in order.
- Flush has priority over every transition except reset. Next state is EMPTY, and any beat accepted in the flush cycle is discarded. In the following cycle out_valid=0 and salida_wb/salida_m read 0. Data outputs may keep stale values.
- Reset (asynchronous assert, synchronous-style release):
  - state EMPTY.
  - All outputs and both registers zero, including stall_cnt.
  - in_ready=0 while rst=1; beats presented during reset are ignored.
  - Reset in the middle of a transfer drops all content.
- stall_cnt increments when out_valid & ~out_ready, saturates at 2^CNT_W-1, and clears only on reset. It still counts in the flush cycle if that cycle's condition holds.
- Widths: jump target = {add131_28, instTipoJ}, exactly DATA_W bits, with no extension or truncation. Data fields pass through unchanged.
- Control gating: salida_wb and salida_m read 0 whenever out_valid=0, so a bubble cannot write to memory or registers.

Test Plan:
1. Reset, then in_valid=1 with resulalu=0x0000_00A5, mux=5'd9, wb=2'b10, out_ready=1. Required: out_valid=1 one cycle later with salidaresulalu=0xA5, salidamux=9, salida_wb=2'b10; in_ready stays 1.
2. Jump assembly: add131_28=4'h4, instTipoJ=28'h0000_100. Required: salidainstTipoJ=32'h4000_0100.
3. Back-pressure: out_ready=0 while packets P1, P2, P3 are offered. Required: P1 and P2 accepted, in_ready=0 after P2, P3 held off, stall_cnt increases by 1 each cycle. Then out_ready=1. Required: order P1, P2, P3, no loss or duplication.
4. Flush in state TWO with in_valid=1. Required: next cycle out_valid=0, salida_m=0, salida_wb=0, in_ready=1; no flushed packet ever appears on the output.
5. Assert rst asynchronously mid-cycle in state ONE. Required: outputs go to 0 immediately and in_ready=0. After release, the first accepted beat appears normally.
6. Set CNT_W=2 and hold out_ready=0 for 6 cycles with out_valid=1. Required: stall_cnt sequence 1, 2, 3, 3, 3, 3.
